// File: rtl/data_mem_dump_pkg.sv
// Shared debug package for the data memory dump engine.
// Holds the dump FSM state type, the byte width of the debug stream and a helper
// giving the number of bytes in a memory word.
//
// Debug byte stream convention (shared with the UART transmitter):
//   - the producer drives byte + valid from registers;
//   - a byte moves on every rising edge where valid && ready;
//   - once valid rises, valid and byte stay unchanged until that transfer;
//   - ready may be high at any time and never feeds back into valid combinationally.
package data_mem_dump_pkg;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_READ,
    DUMP_CAPTURE,
    DUMP_SEND,
    DUMP_DONE
  } dump_state_e;

  localparam int unsigned BYTE_WIDTH         = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / BYTE_WIDTH;

  typedef logic [BYTE_WIDTH-1:0] dbg_byte_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/data_mem_dump_if.sv
// Bus bundle of the dump engine: the BRAM read port plus the debug byte stream.
//   mem_rd_en / mem_addr : read request toward the data memory BRAM
//   mem_data             : read data, valid the cycle after mem_rd_en
//   byte_data/byte_valid : byte toward the UART transmitter
//   byte_ready           : transmitter accepts the byte this cycle
// master = dump engine side, slave = memory + transmitter side.
interface data_mem_dump_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();
  import data_mem_dump_pkg::*;

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  dbg_byte_t             byte_data;
  logic                  byte_valid;
  logic                  byte_ready;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_data,
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_data,
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/data_mem_dump_word_serializer.sv
// word_serializer: loads one DATA_WIDTH word and emits it MSB byte first on a
// valid/ready byte stream.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   load_i/word_i : capture a new word; valid rises on the following cycle
//   byte_o/valid_o/ready_i : registered byte stream
//   last_xfer_o   : the final byte of the word is transferring this cycle
module word_serializer
  import data_mem_dump_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output dbg_byte_t             byte_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_xfer_o
);

  localparam int unsigned Bpw  = bytes_per_word(DATA_WIDTH);
  localparam int unsigned CntW = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  xfer, last;

  assign xfer = valid_q & ready_i;
  assign last = (cnt_q == CntW'(Bpw - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shift_d = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      // The next byte is always on top, so the output needs no mux.
      shift_d = shift_q << BYTE_WIDTH;
      cnt_d   = cnt_q + 1'b1;
      if (last) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign byte_o      = shift_q[DATA_WIDTH-1 -: BYTE_WIDTH];
  assign valid_o     = valid_q;
  assign last_xfer_o = xfer & last;

endmodule

// File: rtl/data_mem_dump.sv
// data_mem_dump: debug read-out of the data memory. A start pulse in IDLE walks
// words 0 .. NUM_WORDS-1, reading each from the BRAM and streaming its bytes MSB
// first toward the debug UART. Never writes memory.
//   clk, i_reset : clock, asynchronous active-high reset
//   i_start      : one-cycle dump request, honoured only in IDLE
//   dump_bus     : BRAM read port + byte stream (master side)
//   o_busy       : dump in progress (cycle after accepted start until DONE left)
//   o_done       : one-cycle pulse after the last byte transfer
module data_mem_dump
  import data_mem_dump_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_start,
  data_mem_dump_if.master  dump_bus,
  output logic             o_busy,
  output logic             o_done
);

  // One extra bit so NUM_WORDS == 2**ADDR_WIDTH is representable.
  localparam int unsigned     IdxW    = ADDR_WIDTH + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  dump_state_e           state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  start_q, start_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  word_done;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        // An accepted start is held one cycle before READ, which gives the
        // start-to-READ spacing and keeps o_busy up during that cycle.
        if (start_q) begin
          state_d = DUMP_READ;
        end else if (i_start) begin
          start_d = 1'b1;
          idx_d   = '0;
        end
      end
      DUMP_READ:    state_d = DUMP_CAPTURE;
      DUMP_CAPTURE: begin
        load    = 1'b1;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (word_done) begin
          if (idx_q == LastIdx) begin
            state_d = DUMP_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DUMP_READ;
          end
        end
      end
      DUMP_DONE:    state_d = DUMP_IDLE;
      default:      state_d = DUMP_IDLE;
    endcase

    // Outputs are computed from the next state so they leave registers.
    rd_en_d = (state_d == DUMP_READ);
    addr_d  = idx_d[ADDR_WIDTH-1:0];
    done_d  = (state_d == DUMP_DONE);
    busy_d  = start_d | (state_d != DUMP_IDLE);
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_serializer (
    .clk_i      (clk),
    .rst_i      (i_reset),
    .load_i     (load),
    .word_i     (dump_bus.mem_data),
    .byte_o     (dump_bus.byte_data),
    .valid_o    (dump_bus.byte_valid),
    .ready_i    (dump_bus.byte_ready),
    .last_xfer_o(word_done)
  );

  assign dump_bus.mem_rd_en = rd_en_q;
  assign dump_bus.mem_addr  = addr_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;

endmodule
